// File: rtl/chunk_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// chunk_serial_adder_pkg : FSM encoding, default sizes, index-width helper
// Revision: 1.0
// ============================================================================
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Never returns 0 so a single-chunk build still has a legal index register.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_serial_adder_if.sv
`default_nettype none
// ============================================================================
// chunk_serial_adder_if : operand/result handshake bundle for the serial adder
// Revision: 1.0
// ============================================================================
interface chunk_serial_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             acc_mode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/chunk_serial_adder_ripple_chunk.sv
`default_nettype none
// ============================================================================
// chunk_serial_adder_ripple_chunk : combinational CHUNK-bit full-adder chain
// Revision: 1.0
// ============================================================================
module chunk_serial_adder_ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  wire logic [CHUNK-1:0] i_a,
  input  wire logic [CHUNK-1:0] i_b,
  input  wire logic             i_cin,
  output logic      [CHUNK-1:0] o_sum,
  output logic                  o_cout,
  output logic                  o_cmsb
);

  logic [CHUNK:0] w_carry;

  always_comb begin
    w_carry    = '0;
    o_sum      = '0;
    w_carry[0] = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_carry[CHUNK];
  // Carry into the chunk's top bit; on the last chunk this is the word's MSB carry-in.
  assign o_cmsb = w_carry[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/chunk_serial_adder.sv
`default_nettype none
// ============================================================================
// chunk_serial_adder : multi-cycle WIDTH-bit adder/accumulator, CHUNK bits/cycle
// Revision: 1.0
// ============================================================================
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  wire logic          clk,
  input  wire logic          rst,
  chunk_serial_adder_if.slave bus
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_IW     = idx_width(WIDTH, CHUNK);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  logic [c_IW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_acc_req;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  int               w_lo;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_chunk_cmsb;
  logic [WIDTH-1:0] w_b_sel;

  assign w_lo = int'(r_idx) * CHUNK;

  // A clear landing on the capture edge must already be visible to the B mux.
  assign w_b_sel = bus.acc_mode ? (bus.acc_clr ? '0 : r_acc) : bus.b;

  chunk_serial_adder_ripple_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a    (r_a[w_lo +: CHUNK]),
    .i_b    (r_b[w_lo +: CHUNK]),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout),
    .o_cmsb (w_chunk_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc_req   <= 1'b0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= w_b_sel;
            r_carry    <= bus.cin;
            r_acc_req  <= bus.acc_mode;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_sum[w_lo +: CHUNK] <= w_chunk_sum;
          r_carry              <= w_chunk_cout;
          r_idx                <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_cout      <= w_chunk_cout;
            r_ovf       <= w_chunk_cmsb ^ w_chunk_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase

      if (bus.acc_clr) begin
        r_acc <= '0;
      end else if ((r_state == ST_DONE) && bus.out_ready && r_acc_req) begin
        r_acc <= r_sum;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunk_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_chunk_serial_adder : directed vector table plus multi-cycle corner cases
// Revision: 1.0
// ============================================================================
module tb_chunk_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunk_serial_adder_if #(.WIDTH(16)) bus ();

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t        vecs [9];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic mode, input logic clr, input int stall,
                       output logic [15:0] s, output logic co, output logic ov,
                       output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.acc_mode = mode;
    bus.acc_clr  = clr;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      n_checks++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
    s  = bus.sum;
    co = bus.cout;
    ov = bus.ovf;
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s, bsel, exp_s;
    logic        co, ov, ok, mode, clr, cin;
    logic [16:0] full;
    logic [15:0] ra, rb;
    int          lat, guard;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.acc_mode = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
    repeat (3) tick();
    check("reset_state", {bus.in_ready, bus.out_valid, bus.cout, bus.ovf, bus.sum},
          {4'b1000, 16'h0000});
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0, 0, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), co, vecs[i].co);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
      check($sformatf("vec%0d_latency", i), lat, 5);
    end

    // accumulate chain
    bus.acc_clr = 1'b1; tick(); bus.acc_clr = 1'b0;
    do_op(16'h0005, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat);
    check("acc_1", s, 16'h0005);
    do_op(16'h0005, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1, s, co, ov, lat);
    check("acc_2", s, 16'h000A);
    do_op(16'h0005, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat);
    check("acc_3", s, 16'h000F);
    bus.acc_clr = 1'b1; tick(); bus.acc_clr = 1'b0;
    do_op(16'h0005, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat);
    check("acc_after_clr", s, 16'h0005);
    do_op(16'h0007, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0, s, co, ov, lat);
    check("acc_clr_on_capture", s, 16'h0007);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0, s, co, ov, lat);
    check("acc_mode0_op", s, 16'h0002);
    do_op(16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat);
    check("acc_unchanged_by_mode0", s, 16'h0008);

    // long stall in DONE with a stray in_valid
    bus.a = 16'h0003; bus.b = 16'h0004; bus.cin = 1'b0; bus.acc_mode = 1'b0;
    bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin tick(); guard++; end
    ok = 1'b1;
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.in_valid = 1'b1;
    repeat (10) begin
      tick();
      if (bus.sum !== 16'h0007 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    check("stall_hold", ok, 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("in_ready_after_handshake", {bus.in_ready, bus.out_valid}, 2'b10);
    tick();
    check("idle_after_stray_valid", {bus.in_ready, bus.out_valid}, 2'b10);

    // reset in the middle of BUSY (idx=2)
    bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; #1;
    check("reset_mid_busy", {bus.in_ready, bus.out_valid, bus.cout, bus.ovf, bus.sum},
          {4'b1000, 16'h0000});
    tick(); rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin tick(); if (bus.out_valid !== 1'b0) ok = 1'b0; end
    check("no_spurious_valid", ok, 1);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 0, s, co, ov, lat);
    check("post_reset_op", s, 16'h0002);

    // randomised ops against a reference model
    model_acc = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      cin  = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 7) == 0);
      bsel = mode ? (clr ? 16'h0000 : model_acc) : rb;
      if (clr) model_acc = 16'h0000;
      full  = {1'b0, ra} + {1'b0, bsel} + {16'h0000, cin};
      exp_s = full[15:0];
      do_op(ra, rb, cin, mode, clr, int'($urandom_range(0, 3)), s, co, ov, lat);
      check($sformatf("rand%0d", i), {13'h0, co, ov, lat[2:0], s},
            {13'h0, full[16], (ra[15] == bsel[15]) && (exp_s[15] != ra[15]), 3'd5, exp_s});
      if (mode) model_acc = exp_s;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
